mem_arbiter: RTL and testbench

Shares one single-ported backing memory between the pipeline's instruction-fetch (IF) port and its data (MEM-stage) port, so the pipelined datapath can run from a unified memory. Each requester issues one access at a time with a req/ack handshake. The arbiter grants MEM-stage accesses first and guards IF against starvation. It drives the backing RAM, which has a fixed read latency, and returns read data to the winning port with a one-cycle ack pulse.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   state_t  : arbiter sequencing states (IDLE, ISSUE, WAIT, DONE)
//   winner_t : which requester owns the access in flight
//   CNT_W    : width of the latency and starvation counters (covers 1..15)
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    WIN_IF  = 1'b0,
    WIN_MEM = 1'b1
  } winner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported backing RAM between the instruction-fetch port
// and the MEM-stage data port. MEM accesses win ties, but after STARVE_MAX
// consecutive MEM grants taken while IF was waiting, IF is forced through.
// Every access takes MEM_LAT+3 cycles from the granting IDLE cycle back to
// IDLE, writes included, so ack timing never depends on the access type.
//
// Ports:
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   if_req/if_addr        : IF read request, held until if_ack
//   if_ack/if_rdata       : one-cycle ack; if_rdata holds until the next IF ack
//   mem_req/mem_we/...    : MEM-stage request (read or write), held until mem_ack
//   mem_ack/mem_rdata     : one-cycle ack; mem_rdata is 0 after a write
//   ram_en/ram_we         : one-cycle strobe and write qualifier to the RAM
//   ram_addr/ram_wdata    : latched address and write data
//   ram_rdata             : RAM read data, valid MEM_LAT cycles after ram_en
//   busy                  : high whenever an access is in flight
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  winner_t          winner;
  logic             we_lat;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] starve_cnt;
  logic             any_req;
  logic             if_wins;

  // IF only beats a pending MEM request once the starvation counter has
  // saturated; otherwise a lone request always wins.
  assign any_req = if_req | mem_req;
  assign if_wins = if_req & (~mem_req | (starve_cnt == STARVE_LIM));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. All outputs come from registers, so
  // nothing on the requester side can ripple straight through to an output.
  always_comb begin
    state_next = state;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    if_ack     = 1'b0;
    mem_ack    = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        ram_en     = 1'b1;
        ram_we     = we_lat;
        state_next = WAIT;
      end
      WAIT: begin
        if (lat_cnt == CNT_ONE) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if_ack     = (winner == WIN_IF);
        mem_ack    = (winner == WIN_MEM);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch the winning request in IDLE, count down the RAM latency,
  // and capture read data into the winner's rdata register on the edge that
  // enters DONE. Requester inputs are deliberately ignored outside IDLE.
  // The starvation counter only moves on grants: IF grants and MEM grants
  // with no IF waiting clear it, MEM grants that make IF wait bump it.
  always_ff @(posedge clk) begin
    if (rst) begin
      winner     <= WIN_IF;
      we_lat     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (if_wins) begin
              winner     <= WIN_IF;
              we_lat     <= 1'b0;
              ram_addr   <= if_addr;
              ram_wdata  <= '0;
              starve_cnt <= '0;
            end else begin
              winner    <= WIN_MEM;
              we_lat    <= mem_we;
              ram_addr  <= mem_addr;
              ram_wdata <= mem_wdata;
              if (if_req) begin
                if (starve_cnt != STARVE_LIM) begin
                  starve_cnt <= starve_cnt + CNT_ONE;
                end
              end else begin
                starve_cnt <= '0;
              end
            end
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_LOAD;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - CNT_ONE;
          if (lat_cnt == CNT_ONE) begin
            if (winner == WIN_IF) begin
              if_rdata <= ram_rdata;
            end else begin
              mem_rdata <= we_lat ? '0 : ram_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Randomized, scoreboarded bench for mem_arbiter. A transaction-level model
// decides who gets each grant and when, and pushes the expected RAM strobe
// and ack/data into queues; a negedge monitor pops and compares them against
// the DUT. The backing RAM is a behavioural model with MEM_LAT read latency.
module tb_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int NUM_CYCLES = 4000;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } issue_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } ack_t;

  typedef struct {
    int          start;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } script_t;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rstLast  = 0;
  int busyFrom = 0;
  int busyTo   = -1;
  int nextFree = 0;
  int starve   = 0;

  issue_t  issueQ[$];
  ack_t    ifQ[$];
  ack_t    memQ[$];
  script_t ifScript[$];
  script_t memScript[$];

  logic [31:0] ram    [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];
  logic [31:0] rdPipe [MEM_LAT];
  logic [31:0] lastIf  = '0;
  logic [31:0] lastMem = '0;

  bit          ifActive   = 0;
  bit          ifGranted  = 0;
  int          ifAckCyc   = 0;
  logic [31:0] ifAddrReal = '0;
  bit          memActive  = 0;
  bit          memGranted = 0;
  int          memAckCyc  = 0;
  logic        memWeReal  = 1'b0;
  logic [31:0] memAddrReal  = '0;
  logic [31:0] memWdataReal = '0;

  mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MEM_LAT(MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_ack(if_ack),
    .if_rdata(if_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .ram_en(ram_en),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .busy(busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten memory words get a recognisable address-derived pattern.
  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  function automatic logic [31:0] randAddr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // Behavioural backing RAM: a write lands on the strobe edge; a read enters
  // a delay line so the word is presented exactly MEM_LAT cycles after the
  // strobe cycle. Every other slot carries random junk so a mistimed capture
  // shows up as wrong data.
  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      rdPipe[i] <= rdPipe[i-1];
    end
    if (ram_en && !ram_we) begin
      rdPipe[0] <= ram.exists(ram_addr) ? ram[ram_addr] : initWord(ram_addr);
    end else begin
      rdPipe[0] <= $urandom;
    end
    if (ram_en && ram_we) begin
      ram[ram_addr] = ram_wdata;
    end
  end
  assign ram_rdata = rdPipe[MEM_LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h required=%h",
               name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus plus the reference model. Requesters release on
  // the cycle after their predicted ack and may re-request immediately.
  // A requester that has been granted scrambles its address/data pins, since
  // the arbiter must only use what it latched in IDLE.
  task automatic applyStimulus(input int c);
    int  prob;
    bit  doRst;
    bit  winIf;
    logic [31:0] d;

    if (ifGranted && c == ifAckCyc + 1) begin
      ifGranted = 0;
      ifActive  = 0;
    end
    if (memGranted && c == memAckCyc + 1) begin
      memGranted = 0;
      memActive  = 0;
    end

    prob = (c < 400) ? 100 : 40;
    if (!ifActive) begin
      if (ifScript.size() > 0 && ifScript[0].start <= c) begin
        ifAddrReal = ifScript[0].addr;
        ifActive   = 1;
        void'(ifScript.pop_front());
      end else if (c >= 100 && $urandom_range(0, 99) < prob) begin
        ifAddrReal = randAddr();
        ifActive   = 1;
      end
    end
    if (!memActive) begin
      if (memScript.size() > 0 && memScript[0].start <= c) begin
        memWeReal    = memScript[0].we;
        memAddrReal  = memScript[0].addr;
        memWdataReal = memScript[0].wdata;
        memActive    = 1;
        void'(memScript.pop_front());
      end else if (c >= 100 && $urandom_range(0, 99) < prob) begin
        memWeReal    = ($urandom_range(0, 2) == 0);
        memAddrReal  = randAddr();
        memWdataReal = $urandom;
        memActive    = 1;
      end
    end

    if_req    = ifActive;
    if_addr   = (ifActive && !ifGranted) ? ifAddrReal : $urandom;
    mem_req   = memActive;
    mem_we    = (memActive && !memGranted) ? memWeReal : 1'($urandom);
    mem_addr  = (memActive && !memGranted) ? memAddrReal : $urandom;
    mem_wdata = (memActive && !memGranted) ? memWdataReal : $urandom;

    doRst = (c <= 2) || (c == 57) || (c >= 400 && $urandom_range(0, 299) == 0);
    rst   = doRst;

    if (doRst) begin
      rstLast  = c;
      starve   = 0;
      nextFree = c + 1;
      if (busyTo > c) busyTo = c;
      while (issueQ.size() > 0 && issueQ[$].cyc > c) void'(issueQ.pop_back());
      while (ifQ.size() > 0 && ifQ[$].cyc > c) void'(ifQ.pop_back());
      while (memQ.size() > 0 && memQ[$].cyc > c) void'(memQ.pop_back());
      if (ifGranted && ifAckCyc > c) ifGranted = 0;
      if (memGranted && memAckCyc > c) memGranted = 0;
    end else if (c >= nextFree && (ifActive || memActive)) begin
      if (ifActive && memActive) winIf = (starve == STARVE_MAX);
      else winIf = ifActive;

      if (winIf) starve = 0;
      else if (ifActive) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
      else starve = 0;

      if (winIf) begin
        d = refRead(ifAddrReal);
        issueQ.push_back('{cyc: c + 1, we: 1'b0, addr: ifAddrReal, wdata: 32'h0});
        ifQ.push_back('{cyc: c + MEM_LAT + 2, data: d});
        ifGranted = 1;
        ifAckCyc  = c + MEM_LAT + 2;
      end else begin
        if (memWeReal) begin
          refMem[memAddrReal] = memWdataReal;
          d = 32'h0;
        end else begin
          d = refRead(memAddrReal);
        end
        issueQ.push_back('{cyc: c + 1, we: memWeReal, addr: memAddrReal,
                           wdata: memWdataReal});
        memQ.push_back('{cyc: c + MEM_LAT + 2, data: d});
        memGranted = 1;
        memAckCyc  = c + MEM_LAT + 2;
      end
      busyFrom = c + 1;
      busyTo   = c + MEM_LAT + 2;
      nextFree = c + MEM_LAT + 3;
    end
  endtask

  // Monitor: on every falling edge, compare the DUT against whatever the
  // model expects for this cycle, and check that nothing happens when the
  // model expects nothing.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (cyc == rstLast + 1) begin
        lastIf  = '0;
        lastMem = '0;
        checkOutput("reset_ram_addr", ram_addr, 32'h0);
        checkOutput("reset_ram_wdata", ram_wdata, 32'h0);
      end

      checkOutput("busy", 32'(busy),
                  32'((cyc >= busyFrom && cyc <= busyTo) ? 1 : 0));

      if (issueQ.size() > 0 && issueQ[0].cyc == cyc) begin
        checkOutput("ram_en", 32'(ram_en), 32'd1);
        checkOutput("ram_we", 32'(ram_we), 32'(issueQ[0].we));
        checkOutput("ram_addr", ram_addr, issueQ[0].addr);
        if (issueQ[0].we) checkOutput("ram_wdata", ram_wdata, issueQ[0].wdata);
        void'(issueQ.pop_front());
      end else begin
        checkOutput("ram_en_idle", 32'(ram_en), 32'd0);
      end

      if (ifQ.size() > 0 && ifQ[0].cyc == cyc) begin
        checkOutput("if_ack", 32'(if_ack), 32'd1);
        checkOutput("if_rdata", if_rdata, ifQ[0].data);
        lastIf = ifQ[0].data;
        void'(ifQ.pop_front());
      end else begin
        checkOutput("if_ack_quiet", 32'(if_ack), 32'd0);
        checkOutput("if_rdata_hold", if_rdata, lastIf);
      end

      if (memQ.size() > 0 && memQ[0].cyc == cyc) begin
        checkOutput("mem_ack", 32'(mem_ack), 32'd1);
        checkOutput("mem_rdata", mem_rdata, memQ[0].data);
        lastMem = memQ[0].data;
        void'(memQ.pop_front());
      end else begin
        checkOutput("mem_ack_quiet", 32'(mem_ack), 32'd0);
        checkOutput("mem_rdata_hold", mem_rdata, lastMem);
      end
    end
  end

  // Driver: reset, a few scripted scenarios (single IF read, write then
  // read-back, simultaneous requests, reset in WAIT), a stretch with both
  // requesters always busy to exercise starvation, then random traffic.
  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    ram[32'h40]    = 32'h1234_ABCD;
    refMem[32'h40] = 32'h1234_ABCD;

    ifScript.push_back('{start: 3, we: 1'b0, addr: 32'h40, wdata: 32'h0});
    ifScript.push_back('{start: 40, we: 1'b0, addr: 32'h44, wdata: 32'h0});
    memScript.push_back('{start: 20, we: 1'b1, addr: 32'h80, wdata: 32'hDEAD_BEEF});
    memScript.push_back('{start: 20, we: 1'b0, addr: 32'h80, wdata: 32'h0});
    memScript.push_back('{start: 40, we: 1'b0, addr: 32'h48, wdata: 32'h0});
    memScript.push_back('{start: 55, we: 1'b0, addr: 32'h80, wdata: 32'h0});

    for (int n = 1; n <= NUM_CYCLES; n++) begin
      @(posedge clk);
      #1;
      cyc = n;
      applyStimulus(n);
    end
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
